score_bcd_counter: RTL and testbench

Accumulates the player score from line-clear events and holds it as packed BCD digits, plus a high-score register updated at each new game. It sits between the game-logic FSM (upstream, reports cleared lines) and the per-digit segment decoders (downstream, one per digit). Each 4-bit digit output is always in 0–9, so it can drive a decoder directly. Points are added serially, one unit per cycle, with a ready/valid handshake toward the game FSM.

---
 rtl/score_bcd_counter_pkg.sv | 27 ++
 rtl/score_bcd_counter_bcd_digit_inc.sv | 22 ++
 rtl/score_bcd_counter.sv | 84 ++++++++
 tb/tb_score_bcd_counter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_bcd_counter_pkg.sv
// Shared types and constants for the BCD score counter.
package score_pkg;

  localparam int unsigned DIGITS_DEFAULT = 4;
  localparam int unsigned PEND_W = 4;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic {
    IDLE,
    ADD
  } state_t;

  // Score awarded per clear event; out-of-range line counts award nothing.
  function automatic logic [PEND_W-1:0] points(input logic [2:0] lines);
    logic [PEND_W-1:0] p;
    p = '0;
    case (lines)
      3'd1:    p = PEND_W'(1);
      3'd2:    p = PEND_W'(3);
      3'd3:    p = PEND_W'(5);
      3'd4:    p = PEND_W'(8);
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/score_bcd_counter_bcd_digit_inc.sv
// One BCD digit of a ripple incrementer: adds carry_in, wraps 9 to 0.
module bcd_digit_inc (
  input  logic [3:0] digit_in,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  always_comb begin
    digit_out = digit_in;
    carry_out = 1'b0;
    if (carry_in) begin
      if (digit_in == 4'd9) begin
        digit_out = '0;
        carry_out = 1'b1;
      end else begin
        digit_out = digit_in + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Serial BCD score accumulator with high-score register and ready/valid intake.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_valid,
  input  logic [2:0]            clear_lines,
  output logic                  clear_ready,
  input  logic                  new_game,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic                  saturated
);

  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  state_t              state;
  logic [PEND_W-1:0]   pending;
  logic [4*DIGITS-1:0] score_q;
  logic [4*DIGITS-1:0] high_q;
  logic                sat_q;
  logic [4*DIGITS-1:0] score_inc;
  logic [DIGITS:0]     carry;
  logic                accept;
  logic [PEND_W-1:0]   evt_points;

  assign carry[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_inc u_inc (
      .digit_in  (score_q[4*k +: 4]),
      .carry_in  (carry[k]),
      .digit_out (score_inc[4*k +: 4]),
      .carry_out (carry[k+1])
    );
  end

  assign clear_ready = (state == IDLE) && !rst;
  assign accept      = clear_valid && clear_ready && !new_game;
  assign evt_points  = points(clear_lines);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      score_q <= '0;
      high_q  <= '0;
      sat_q   <= 1'b0;
    end else if (new_game) begin
      high_q  <= (score_q > high_q) ? score_q : high_q;
      score_q <= '0;
      pending <= '0;
      sat_q   <= 1'b0;
      state   <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (evt_points != '0)) begin
            pending <= evt_points;
            state   <= ADD;
          end
        end
        ADD: begin
          // At all nines the score freezes; pending still drains so timing is unchanged.
          if (score_q != NINES) begin
            score_q <= score_inc;
            sat_q   <= (score_inc == NINES);
          end
          pending <= pending - PEND_ONE;
          if (pending == PEND_ONE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench for score_bcd_counter: directed table, corner sequences, random vs model.
module tb_score_bcd_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_valid = 1'b0;
  logic [2:0]  clear_lines = '0;
  logic        new_game = 1'b0;
  logic        clear_ready;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        saturated;

  logic        b_valid = 1'b0;
  logic [2:0]  b_lines = '0;
  logic        b_ng = 1'b0;
  logic        b_ready;
  logic [7:0]  b_score;
  logic [7:0]  b_high;
  logic        b_sat;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: decimal integers, pending count replaces any state machine.
  int m_score = 0;
  int m_high  = 0;
  int m_pend  = 0;
  localparam int M_MAX = 9999;

  always #5 clk = ~clk;

  score_bcd_counter #(.DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_valid (clear_valid),
    .clear_lines (clear_lines),
    .clear_ready (clear_ready),
    .new_game    (new_game),
    .score_bcd   (score_bcd),
    .high_bcd    (high_bcd),
    .saturated   (saturated)
  );

  score_bcd_counter #(.DIGITS(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .clear_valid (b_valid),
    .clear_lines (b_lines),
    .clear_ready (b_ready),
    .new_game    (b_ng),
    .score_bcd   (b_score),
    .high_bcd    (b_high),
    .saturated   (b_sat)
  );

  function automatic int pts(input logic [2:0] l);
    case (l)
      3'd1: return 1;
      3'd2: return 3;
      3'd3: return 5;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] tobcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic nibbles_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic v, input logic [2:0] l, input logic ng, input logic r);
    if (r) begin
      m_score = 0; m_high = 0; m_pend = 0;
    end else if (ng) begin
      if (m_score > m_high) m_high = m_score;
      m_score = 0; m_pend = 0;
    end else if (m_pend > 0) begin
      if (m_score < M_MAX) m_score++;
      m_pend--;
    end else if (v) begin
      m_pend = pts(l);
    end
  endtask

  task automatic check_model();
    chk("model_score", 32'(score_bcd), 32'(tobcd(m_score)));
    chk("model_high", 32'(high_bcd), 32'(tobcd(m_high)));
    chk("model_sat", 32'(saturated), 32'(m_score == M_MAX));
    chk("model_ready", 32'(clear_ready), 32'((m_pend == 0) && !rst));
  endtask

  task automatic step(input logic v, input logic [2:0] l, input logic ng, input logic r);
    clear_valid = v;
    clear_lines = l;
    new_game    = ng;
    rst         = r;
    @(posedge clk);
    model_update(v, l, ng, r);
    #1;
    check_model();
  endtask

  task automatic run_event(input logic [2:0] l);
    step(1'b1, l, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !clear_ready; i++) begin
      step(1'b0, 3'd0, 1'b0, 1'b0);
      chk("nibble_range", 32'(nibbles_ok(score_bcd)), 32'd1);
    end
    chk("ready_after_event", 32'(clear_ready), 32'd1);
  endtask

  task automatic run_event_b(input logic [2:0] l);
    b_valid = 1'b1;
    b_lines = l;
    step(1'b0, 3'd0, 1'b0, 1'b0);
    b_valid = 1'b0;
    for (int i = 0; i < 20 && !b_ready; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("b_ready_after_event", 32'(b_ready), 32'd1);
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  l;
    logic        ng;
    logic        r;
    logic [15:0] exp_score;
    logic [15:0] exp_high;
    logic        exp_ready;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'd4, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
    for (int i = 1; i <= 7; i++)
      vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 16'(i), 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 16'h0008, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 16'h0008, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 1'b0, 1'b0, 16'h0008, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'd7, 1'b0, 1'b0, 16'h0008, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].l, vecs[i].ng, vecs[i].r);
      chk("tbl_score", 32'(score_bcd), 32'(vecs[i].exp_score));
      chk("tbl_high", 32'(high_bcd), 32'(vecs[i].exp_high));
      chk("tbl_ready", 32'(clear_ready), 32'(vecs[i].exp_ready));
      chk("tbl_sat", 32'(saturated), 32'(vecs[i].exp_sat));
    end

    // Decimal carry across two digits: 99 -> 100.
    for (int i = 0; i < 12; i++) run_event(3'd4);
    run_event(3'd2);
    chk("score_99", 32'(score_bcd), 32'h0099);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("score_100", 32'(score_bcd), 32'h0100);
    chk("ready_after_100", 32'(clear_ready), 32'd1);

    // Two-digit instance saturates at 99.
    for (int i = 0; i < 12; i++) run_event_b(3'd4);
    run_event_b(3'd2);
    chk("b_score_99", 32'(b_score), 32'h99);
    chk("b_sat", 32'(b_sat), 32'd1);
    b_valid = 1'b1;
    b_lines = 3'd2;
    step(1'b0, 3'd0, 1'b0, 1'b0);
    b_valid = 1'b0;
    cnt = 0;
    while (!b_ready && cnt < 20) begin
      cnt++;
      step(1'b0, 3'd0, 1'b0, 1'b0);
      chk("b_score_hold", 32'(b_score), 32'h99);
    end
    chk("b_busy_cycles", 32'(cnt), 32'd3);
    chk("b_sat_hold", 32'(b_sat), 32'd1);
    chk("b_score_final", 32'(b_score), 32'h99);

    // new_game on the second ADD cycle loses the rest of the event.
    step(1'b0, 3'd0, 1'b0, 1'b1);
    run_event(3'd3);
    chk("score_5", 32'(score_bcd), 32'h0005);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("ng_high", 32'(high_bcd), 32'h0006);
    chk("ng_score", 32'(score_bcd), 32'h0000);
    chk("ng_ready", 32'(clear_ready), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("ng_points_lost", 32'(score_bcd), 32'h0000);

    // Back-to-back games: high keeps the better one.
    run_event(3'd4); run_event(3'd2); run_event(3'd1);
    chk("game1_score", 32'(score_bcd), 32'h0012);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("game1_high", 32'(high_bcd), 32'h0012);
    run_event(3'd3); run_event(3'd1); run_event(3'd1);
    chk("game2_score", 32'(score_bcd), 32'h0007);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("game2_high", 32'(high_bcd), 32'h0012);

    // Reset in the middle of an ADD run.
    step(1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    chk("rst_score", 32'(score_bcd), 32'h0000);
    chk("rst_high", 32'(high_bcd), 32'h0000);
    chk("rst_sat", 32'(saturated), 32'd0);
    chk("rst_ready", 32'(clear_ready), 32'd0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("post_rst_ready", 32'(clear_ready), 32'd1);
    chk("post_rst_score", 32'(score_bcd), 32'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
